// File: rtl/seven_seg_scanner_if.sv
// Bus between the display host (load side) and the multiplexed 8-digit
// seven-segment driver (scan side).
interface seven_seg_scanner_if;
    logic        load;
    logic [31:0] value;
    logic [7:0]  digit_en;
    logic [7:0]  dp_en;
    logic [2:0]  digit_sel;
    logic [6:0]  seg;
    logic        dp_n;
    logic        slot_tick;

    modport master (
        output load,
        output value,
        output digit_en,
        output dp_en,
        input  digit_sel,
        input  seg,
        input  dp_n,
        input  slot_tick
    );

    modport slave (
        input  load,
        input  value,
        input  digit_en,
        input  dp_en,
        output digit_sel,
        output seg,
        output dp_n,
        output slot_tick
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 8-digit hex display scanner with per-slot anti-ghost
// blanking and frame-synchronous double-buffered display data.
module seven_seg_scanner #(
    parameter int CLK_DIV   = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    seven_seg_scanner_if.slave bus
);

    localparam int                CNT_W     = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [0:0]        ST_BLANK  = 1'b0;
    localparam logic [0:0]        ST_SHOW   = 1'b1;
    localparam logic [6:0]        SEG_OFF   = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

    logic [CNT_W-1:0] div_cnt_r;
    logic [CNT_W-1:0] div_cnt_nxt_s;
    logic [2:0]       digit_sel_r;
    logic [2:0]       digit_sel_nxt_s;
    logic             slot_end_s;
    logic             frame_end_s;
    logic [0:0]       state_r;
    logic [0:0]       state_nxt_s;

    logic [31:0]      act_val_r;
    logic [7:0]       act_en_r;
    logic [7:0]       act_dp_r;
    logic [31:0]      act_val_nxt_s;
    logic [7:0]       act_en_nxt_s;
    logic [7:0]       act_dp_nxt_s;
    logic [31:0]      pend_val_r;
    logic [7:0]       pend_en_r;
    logic [7:0]       pend_dp_r;
    logic             pend_valid_r;
    logic [31:0]      pend_val_nxt_s;
    logic [7:0]       pend_en_nxt_s;
    logic [7:0]       pend_dp_nxt_s;
    logic             pend_valid_nxt_s;

    logic             lit_nxt_s;
    logic [3:0]       nib_nxt_s;
    logic [6:0]       seg_nxt_s;
    logic             dp_n_nxt_s;
    logic [6:0]       seg_r;
    logic             dp_n_r;
    logic             slot_tick_r;

    // Slot divider and digit index advance.
    always_comb begin
        slot_end_s  = (div_cnt_r == DIV_LAST);
        frame_end_s = slot_end_s && (digit_sel_r == 3'd7);
        if (slot_end_s) begin
            div_cnt_nxt_s   = {CNT_W{1'b0}};
            digit_sel_nxt_s = digit_sel_r + 3'd1;
        end else begin
            div_cnt_nxt_s   = div_cnt_r + CNT_ONE;
            digit_sel_nxt_s = digit_sel_r;
        end
    end

    // Per-slot BLANK/SHOW sequencing; a slot always opens blanked.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_BLANK: begin
                if (div_cnt_nxt_s >= BLANK_END) begin
                    state_nxt_s = ST_SHOW;
                end else begin
                    state_nxt_s = ST_BLANK;
                end
            end
            ST_SHOW: begin
                if (slot_end_s) begin
                    state_nxt_s = ST_BLANK;
                end else begin
                    state_nxt_s = ST_SHOW;
                end
            end
            default: state_nxt_s = ST_BLANK;
        endcase
    end

    // Double buffer: loads land in pending, active only swaps on the 7->0 edge.
    // A load on that very edge bypasses pending so it is not a frame late.
    always_comb begin
        act_val_nxt_s    = act_val_r;
        act_en_nxt_s     = act_en_r;
        act_dp_nxt_s     = act_dp_r;
        pend_val_nxt_s   = pend_val_r;
        pend_en_nxt_s    = pend_en_r;
        pend_dp_nxt_s    = pend_dp_r;
        pend_valid_nxt_s = pend_valid_r;
        if (frame_end_s) begin
            pend_valid_nxt_s = 1'b0;
            if (bus.load) begin
                act_val_nxt_s = bus.value;
                act_en_nxt_s  = bus.digit_en;
                act_dp_nxt_s  = bus.dp_en;
            end else if (pend_valid_r) begin
                act_val_nxt_s = pend_val_r;
                act_en_nxt_s  = pend_en_r;
                act_dp_nxt_s  = pend_dp_r;
            end else begin
                act_val_nxt_s = act_val_r;
                act_en_nxt_s  = act_en_r;
                act_dp_nxt_s  = act_dp_r;
            end
        end else begin
            if (bus.load) begin
                pend_val_nxt_s   = bus.value;
                pend_en_nxt_s    = bus.digit_en;
                pend_dp_nxt_s    = bus.dp_en;
                pend_valid_nxt_s = 1'b1;
            end else begin
                pend_valid_nxt_s = pend_valid_r;
            end
        end
    end

    // Next-cycle cathode image. Active data only changes on an edge whose
    // next state is BLANK, so using the current active registers is safe.
    always_comb begin
        lit_nxt_s = (state_nxt_s == ST_SHOW) && act_en_r[digit_sel_nxt_s];
        nib_nxt_s = act_val_r[{digit_sel_nxt_s, 2'b00} +: 4];
        if (lit_nxt_s) begin
            seg_nxt_s  = hex_to_seg(nib_nxt_s);
            dp_n_nxt_s = ~act_dp_r[digit_sel_nxt_s];
        end else begin
            seg_nxt_s  = SEG_OFF;
            dp_n_nxt_s = 1'b1;
        end
    end

    // Scan position, slot FSM and slot tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r   <= {CNT_W{1'b0}};
            digit_sel_r <= 3'd0;
            state_r     <= ST_BLANK;
            slot_tick_r <= 1'b0;
        end else begin
            div_cnt_r   <= div_cnt_nxt_s;
            digit_sel_r <= digit_sel_nxt_s;
            state_r     <= state_nxt_s;
            slot_tick_r <= slot_end_s;
        end
    end

    // Active and pending display buffers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_val_r    <= 32'd0;
            act_en_r     <= 8'd0;
            act_dp_r     <= 8'd0;
            pend_val_r   <= 32'd0;
            pend_en_r    <= 8'd0;
            pend_dp_r    <= 8'd0;
            pend_valid_r <= 1'b0;
        end else begin
            act_val_r    <= act_val_nxt_s;
            act_en_r     <= act_en_nxt_s;
            act_dp_r     <= act_dp_nxt_s;
            pend_val_r   <= pend_val_nxt_s;
            pend_en_r    <= pend_en_nxt_s;
            pend_dp_r    <= pend_dp_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
        end
    end

    // Registered cathode and decimal-point drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r  <= SEG_OFF;
            dp_n_r <= 1'b1;
        end else begin
            seg_r  <= seg_nxt_s;
            dp_n_r <= dp_n_nxt_s;
        end
    end

    assign bus.digit_sel = digit_sel_r;
    assign bus.seg       = seg_r;
    assign bus.dp_n      = dp_n_r;
    assign bus.slot_tick = slot_tick_r;

endmodule
